// File: rtl/deserializer.sv
// deserializer: collects out_bit_width/in_bit_width narrow words (first word in the LSB slice) into one wide word.
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   data_ready - producer offers data_in this cycle
//   read_data  - narrow word is accepted this cycle (data_ready && read_data)
//   data_in    - narrow input word
//   write_data - data_out holds a valid wide word
//   out_ready  - consumer takes data_out this cycle
//   data_out   - assembled wide word, held after consumption
module deserializer #(
  parameter int in_bit_width  = 32,
  parameter int out_bit_width = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_ready,
  output logic                     read_data,
  input  logic [in_bit_width-1:0]  data_in,
  output logic                     write_data,
  input  logic                     out_ready,
  output logic [out_bit_width-1:0] data_out
);
  localparam int n  = out_bit_width / in_bit_width;
  localparam int cw = $clog2(n);
  localparam int aw = out_bit_width - in_bit_width;
  logic [cw-1:0]            seg_q, seg_d;
  logic [aw-1:0]            asm_q, asm_d;
  logic [out_bit_width-1:0] out_q, out_d;
  logic                     wr_q, wr_d, last, accept;
  assign last = seg_q == cw'(n - 1);
  // Only the last segment needs the output slot; a consume on the same edge frees it, hence the out_ready term.
  assign read_data  = reset && !(last && wr_q && !out_ready);
  assign accept     = data_ready && read_data;
  assign write_data = wr_q;
  assign data_out   = out_q;
  always_comb begin
    seg_d = accept ? (last ? '0 : seg_q + 1'b1) : seg_q;
    asm_d = asm_q;
    for (int i = 0; i < n - 1; i++)
      if (accept && seg_q == cw'(i)) asm_d[i*in_bit_width +: in_bit_width] = data_in;
    // The last segment goes straight to the output, bypassing the assembly register.
    out_d = accept && last ? {data_in, asm_q} : out_q;
    wr_d  = accept && last ? 1'b1 : wr_q && !out_ready;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      seg_q <= '0;
      asm_q <= '0;
      out_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      asm_q <= asm_d;
      out_q <= out_d;
      wr_q  <= wr_d;
    end
endmodule

// File: doc/deserializer.md
# deserializer

Narrow-to-wide converter and the receive-side counterpart of the serializer. It collects `num_segments = out_bit_width / in_bit_width` consecutive narrow words and presents them as one wide word. Segment 0, the first word received, lands in the least-significant slice, so a serializer→deserializer pair round-trips data unchanged. A one-deep output register with a consumer handshake lets one wide word be held under backpressure while the next word is assembled.

## Interface

Parameters:
- `in_bit_width`, default 32: narrow (serial-side) word width.
- `out_bit_width`, default 512: wide (parallel-side) word width.
  - Must be an integer multiple of `in_bit_width`, with ratio ≥ 2.
  - Default ratio gives `num_segments` = 16.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `data_ready`  in  1  producer has a valid narrow word on `data_in` this cycle.
- `read_data`  out  1  deserializer accepts `data_in` this cycle.
- `data_in`  in  `in_bit_width`  narrow input word.
- `write_data`  out  1  `data_out` holds a valid wide word.
- `out_ready`  in  1  consumer takes `data_out` this cycle.
- `data_out`  out  `out_bit_width`  assembled wide word.

## Operation

- **Segment transfer:** a narrow word transfers on a rising edge where `data_ready && read_data`.
  - The producer holds `data_in` stable while `data_ready`=1 and `read_data`=0.
- **Assembly state:**
  - Segment counter `seg_cnt`, range 0..num_segments-1, wraps to 0.
  - Assembly register of width `out_bit_width - in_bit_width`.
- **Accepting segment k < num_segments-1:** store into assembly slice `[k*in_bit_width +: in_bit_width]`; `seg_cnt` ← k+1.
- **Accepting the last segment (k = num_segments-1):**
  - `data_out` ← {`data_in`, assembly}.
  - `write_data` ← 1.
  - `seg_cnt` ← 0.
  - The last segment bypasses the assembly register.
- **Output slot:**
  - Consumed on a rising edge where `write_data && out_ready`.
  - If no new word loads on that edge, `write_data` ← 0.
  - `data_out` keeps its last value after consumption; it is not cleared.
- **Flow control:** `read_data` = `reset` && !(`seg_cnt` == num_segments-1 && `write_data` && !`out_ready`).
  - Only completion of a word can stall the input; segments 0..N-2 are always accepted, even while the output slot is full.
  - `read_data` depends combinationally on `out_ready`. This is intentional and gives same-cycle slot reuse.
- **Simultaneous load and consume:** last-segment accept and output consume on the same edge loads the new word, and `write_data` stays 1.
- **Idle behaviour:** while `data_ready`=0, all state holds. No timeout; a partial word is held indefinitely.

## Timing

- **Reset values** while `reset`=0 (asynchronous): `write_data`=0, `data_out`=0, `seg_cnt`=0, assembly=0, `read_data`=0.
- **First cycle after release:** `read_data`=1.
- **Latency:** the last segment accepted at edge t gives `write_data`=1 and valid `data_out` immediately after edge t.
- **Throughput:**
  - Continuous `data_ready`=1 with `out_ready`=1: one narrow word per cycle, no bubbles.
  - `write_data` is a 1-cycle pulse every num_segments cycles.
- **Backpressure:** with `out_ready`=0 and `write_data`=1, at most num_segments-1 further segments are accepted. `read_data` then drops until `out_ready` rises.
- **Reset mid-word:** the partial assembly and any pending output word are discarded. The first segment accepted after release is segment 0.

## Test plan

- **Reset:** hold `reset`=0 with `data_ready`=1 → `read_data`=0, `write_data`=0, `data_out`=0. Release → `read_data`=1 on the next cycle.
- **Full-rate stream:** feed 0..31 with `data_ready`=1 and `out_ready`=1 →
  - two `write_data` pulses, 16 cycles apart;
  - word0 slice i = i, word1 slice i = 16+i;
  - each pulse occurs right after the edge that accepted 15 and 31 respectively.
- **Gapped input:** toggle `data_ready` every cycle while feeding 0..15 → only valid cycles are accepted. A single word with slice i = i appears after the edge accepting 15.
- **Backpressure:**
  - Setup: `out_ready`=0 after the first word; keep streaming 16..
  - Segments 16..30 are accepted; `read_data`=0 while 31 is presented; `data_out` stays word0.
  - Raise `out_ready` → `read_data`=1 in the same cycle. On that edge word1 (16..31) loads and `write_data` stays 1.
- **Reset mid-word:** accept 7 segments (0..6), pulse `reset` low, then feed 100..115 → one word with slice i = 100+i; no word contains 0..6.
- **Width variant:** `in_bit_width`=8, `out_bit_width`=32, stream 0xA1,0xB2,0xC3,0xD4 → `data_out`=0xD4C3B2A1 with a `write_data` pulse.
